// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   BYTE_W  : width of a byte on the transmitter interface
//   state_t : sequencer states of uart_tx_feeder
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. rd_data always shows the head entry.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_data    : push (ignored while full)
//   rd_en, rd_data    : pop (ignored while empty), head data
//   full, empty, count: occupancy status, count in 0..DEPTH
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // full is judged on the pre-edge count, so a push into a full FIFO is
  // dropped even if a pop happens on the same edge.
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and sequencer feeding the UART transmitter.
// Producers push bytes into a FIFO; the sequencer pops one byte at a time,
// presents it on tx_data with tx_start, and paces on tx_ready.
// Ports:
//   clk, rst              : uart clock, synchronous active-high reset
//   wr_en, wr_data        : producer push
//   full, empty, count    : FIFO status
//   tx_data, tx_start     : to transmitter data_in / start
//   tx_ready              : transmitter idle (high = idle)
//   busy                  : a byte is in flight
//   overflow, tx_err      : sticky push-while-full / start-ack timeout
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [BYTE_W-1:0]       wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    overflow,
  output logic                    tx_err
);

  localparam int unsigned     TW         = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  state_t             r_state;
  logic [BYTE_W-1:0]  r_tx_data;
  logic               r_tx_start;
  logic [TW-1:0]      r_timer;
  logic               r_overflow;
  logic               r_tx_err;
  logic [BYTE_W-1:0]  w_head;
  logic               w_pop;

  assign w_pop = (r_state == ST_IDLE) && !empty && tx_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // r_timer counts completed START cycles; tx_start is therefore held for
  // exactly ACK_TIMEOUT cycles when tx_ready never falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_timer    <= '0;
      r_overflow <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_timer    <= '0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (!tx_ready) begin
            r_tx_start <= 1'b0;
            r_state    <= ST_WAIT_DONE;
          end else if (r_timer == TIMER_LAST) begin
            r_tx_start <= 1'b0;
            r_tx_err   <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign busy     = (r_state != ST_IDLE);
  assign overflow = r_overflow;
  assign tx_err   = r_tx_err;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int ACK   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       busy;
  logic       overflow;
  logic       tx_err;

  int n_total = 0;
  int n_bad   = 0;

  uart_tx_feeder #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overflow (overflow),
    .tx_err   (tx_err)
  );

  always #5 clk = ~clk;

  // Reference: byte queue plus the one byte currently handed to the transmitter.
  logic [7:0] m_q[$];
  bit         m_inflight, m_acked, m_start, m_ovf, m_err;
  logic [7:0] m_data;
  int         m_t0;
  int         cyc = 0;

  // Transmitter model.
  int xmode = 0;   // 0 reactive, 1 ready held low, 2 ready stuck high
  int xs = 0, xcnt = 0, ack_dly = 0, busy_len = 1;
  bit rand_xmt = 0;

  logic [7:0] sent_obs[$];
  bit         prev_start = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit was_full;
    if (rst) begin
      m_q.delete();
      m_inflight = 0; m_acked = 0; m_start = 0;
      m_ovf = 0; m_err = 0; m_data = 8'h00;
    end else begin
      was_full = (m_q.size() == DEPTH);
      if (!m_inflight) begin
        if (m_q.size() > 0 && tx_ready) begin
          m_data = m_q.pop_front();
          m_inflight = 1; m_acked = 0; m_start = 1; m_t0 = cyc;
        end
      end else if (!m_acked) begin
        if (!tx_ready) begin
          m_acked = 1; m_start = 0;
        end else if (cyc - m_t0 == ACK) begin
          m_err = 1; m_inflight = 0; m_start = 0;
        end
      end else if (tx_ready) begin
        m_inflight = 0;
      end
      if (wr_en) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back(wr_data);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("count",    32'(count),    32'(m_q.size()));
    check_eq("full",     32'(full),     32'(m_q.size() == DEPTH));
    check_eq("empty",    32'(empty),    32'(m_q.size() == 0));
    check_eq("tx_start", 32'(tx_start), 32'(m_start));
    check_eq("tx_data",  32'(tx_data),  32'(m_data));
    check_eq("busy",     32'(busy),     32'(m_inflight));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("tx_err",   32'(tx_err),   32'(m_err));
    if (tx_start === 1'b1 && !prev_start) sent_obs.push_back(tx_data);
    prev_start = (tx_start === 1'b1);
  endtask

  task automatic xmt_drive();
    if (xmode == 1) begin
      tx_ready = 1'b0;
    end else if (xmode == 2) begin
      tx_ready = 1'b1;
    end else begin
      if (xs == 0) begin
        tx_ready = 1'b1;
        if (tx_start === 1'b1) begin
          if (rand_xmt) begin
            ack_dly  = ($urandom_range(0, 24) == 0) ? 70 : int'($urandom_range(0, 4));
            busy_len = $urandom_range(1, 12);
          end
          xcnt = ack_dly;
          xs = 1;
        end
      end
      if (xs == 1) begin
        if (xcnt == 0) begin
          tx_ready = 1'b0; xcnt = busy_len; xs = 2;
        end else begin
          xcnt--;
        end
      end else if (xs == 2) begin
        if (xcnt <= 1) begin
          tx_ready = 1'b1; xs = 0;
        end else begin
          xcnt--;
        end
      end
    end
  endtask

  task automatic cyc_step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
    xmt_drive();
  endtask

  task automatic run_idle(input string tag, input int limit);
    wr_en = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!m_inflight && m_q.size() == 0) break;
      cyc_step();
    end
    cyc_step();
    check_eq({tag, " drained"}, 32'({busy, empty}), 32'b01);
  endtask

  initial begin
    logic [7:0] hello[5];
    logic [7:0] d2;
    int peak, hi, n;
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_ready = 1'b1;
    cyc_step(); cyc_step();
    check_eq("reset count", 32'(count), 32'd0);
    check_eq("reset empty", 32'(empty), 32'd1);
    rst = 1'b0;
    cyc_step();

    // Single byte, 1-cycle latency.
    xmode = 0; xs = 0; ack_dly = 3; busy_len = 4;
    wr_en = 1'b1; wr_data = 8'h48;
    cyc_step();
    wr_en = 1'b0;
    cyc_step();
    check_eq("t1 start", 32'(tx_start), 32'd1);
    check_eq("t1 data",  32'(tx_data),  32'h48);
    run_idle("t1", 100);

    // HELLO burst against a slow transmitter.
    sent_obs.delete();
    ack_dly = 1; busy_len = 10; peak = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = hello[i];
      cyc_step();
      if (int'(count) > peak) peak = int'(count);
    end
    run_idle("t2", 400);
    check_eq("t2 peak", 32'(peak), 32'd4);
    check_eq("t2 nsent", 32'(sent_obs.size()), 32'd5);
    n = (sent_obs.size() < 5) ? sent_obs.size() : 5;
    for (int i = 0; i < n; i++) check_eq("t2 order", 32'(sent_obs[i]), 32'(hello[i]));
    check_eq("t2 overflow", 32'(overflow), 32'd0);

    // Fill past capacity with the transmitter stalled.
    xmode = 1; tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      cyc_step();
    end
    wr_en = 1'b0;
    cyc_step();
    check_eq("t3 count", 32'(count), 32'd16);
    check_eq("t3 full", 32'(full), 32'd1);
    check_eq("t3 overflow", 32'(overflow), 32'd1);

    // Push and pop on the same edge while full.
    xmode = 0; xs = 0; ack_dly = 2; busy_len = 3; tx_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'hAA;
    cyc_step();
    wr_en = 1'b0;
    check_eq("t4 count", 32'(count), 32'd15);
    check_eq("t4 overflow", 32'(overflow), 32'd1);
    run_idle("t4", 1000);
    check_eq("t4 overflow sticky", 32'(overflow), 32'd1);

    // tx_ready stuck high: start-ack timeout.
    xmode = 2; tx_ready = 1'b1; hi = 0;
    d2 = 8'($urandom);
    wr_en = 1'b1; wr_data = 8'($urandom);
    cyc_step();
    wr_en = 1'b1; wr_data = d2;
    cyc_step();
    wr_en = 1'b0;
    if (tx_start === 1'b1) hi++;
    for (int i = 0; i < 200 && tx_start === 1'b1; i++) begin
      cyc_step();
      if (tx_start === 1'b1) hi++;
    end
    check_eq("t5 start cycles", 32'(hi), 32'd64);
    check_eq("t5 tx_err", 32'(tx_err), 32'd1);
    cyc_step();
    check_eq("t5 next start", 32'(tx_start), 32'd1);
    check_eq("t5 next data", 32'(tx_data), 32'(d2));
    xmode = 0; xs = 0; ack_dly = 0; busy_len = 2;
    run_idle("t5", 200);

    // Reset during WAIT_DONE with bytes queued.
    ack_dly = 1; busy_len = 30;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      cyc_step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_inflight && m_acked && m_q.size() == 3) break;
      cyc_step();
    end
    check_eq("t6 pre count", 32'(count), 32'd3);
    rst = 1'b1;
    cyc_step();
    rst = 1'b0; xs = 0; tx_ready = 1'b1;
    check_eq("t6 count", 32'(count), 32'd0);
    check_eq("t6 tx_start", 32'(tx_start), 32'd0);
    check_eq("t6 busy", 32'(busy), 32'd0);
    check_eq("t6 flags", 32'({overflow, tx_err}), 32'd0);
    busy_len = 3;
    wr_en = 1'b1; wr_data = 8'h5A;
    cyc_step();
    wr_en = 1'b0;
    cyc_step();
    check_eq("t6 restart data", 32'(tx_data), 32'h5A);
    run_idle("t6", 100);

    // Random producer against a randomly paced transmitter.
    rand_xmt = 1;
    for (int i = 0; i < 2000; i++) begin
      wr_en = ($urandom_range(0, 9) < 4);
      wr_data = 8'($urandom);
      cyc_step();
    end
    run_idle("rand", 4000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
